// File: rtl/block_dispatcher_if.sv
// Kernel control and per-core dispatch bus for block_dispatcher.
// The master side is the dispatcher. The slave side is the GPU top level together with its compute cores.
interface block_dispatcher_if #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 8,
  parameter int BLOCK_ID_BITS     = 8,
  parameter int CYCLE_COUNT_BITS  = 16
);
  localparam int CNT_BITS = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                     start;
  logic                                     abort;
  logic [THREAD_COUNT_BITS-1:0]             thread_count;
  logic [NUM_CORES-1:0]                     core_done;
  logic [NUM_CORES-1:0]                     core_start;
  logic [NUM_CORES-1:0]                     core_reset;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0]  core_block_id;
  logic [NUM_CORES-1:0][CNT_BITS-1:0]       core_thread_count;
  logic                                     done;
  logic                                     busy;
  logic                                     aborted;
  logic [CYCLE_COUNT_BITS-1:0]              kernel_cycles;

  modport master (
    input  start, abort, thread_count, core_done,
    output core_start, core_reset, core_block_id, core_thread_count,
           done, busy, aborted, kernel_cycles
  );

  modport slave (
    output start, abort, thread_count, core_done,
    input  core_start, core_reset, core_block_id, core_thread_count,
           done, busy, aborted, kernel_cycles
  );
endinterface

// File: rtl/block_dispatcher.sv
// Kernel block dispatcher.
// It splits a kernel's thread count into fixed-size blocks.
// Blocks go to the lowest-index free core, at most one per cycle.
// It counts completions, supports abort, and can re-launch from DONE.
module block_dispatcher #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_COUNT_BITS = 8,
  parameter int BLOCK_ID_BITS     = 8,
  parameter int CYCLE_COUNT_BITS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  block_dispatcher_if.master bus
);
  localparam int LOG_TPB  = $clog2(THREADS_PER_BLOCK);
  localparam int CNT_BITS = LOG_TPB + 1;
  localparam int WIDE     = THREAD_COUNT_BITS + 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DONE} state_t;

  state_t                                   state_q;
  logic [NUM_CORES-1:0]                     coreStart_q;
  logic [NUM_CORES-1:0]                     coreReset_q;
  logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0]  coreBlockId_q;
  logic [NUM_CORES-1:0][CNT_BITS-1:0]       coreThreadCount_q;
  logic [WIDE-1:0]                          totalBlocks_q;
  logic [WIDE-1:0]                          dispatched_q;
  logic [WIDE-1:0]                          completed_q;
  logic [CNT_BITS-1:0]                      lastCount_q;
  logic                                     done_q;
  logic                                     busy_q;
  logic                                     aborted_q;
  logic [CYCLE_COUNT_BITS-1:0]              kernelCycles_q;

  logic [WIDE-1:0]      launchBlocks;
  logic [CNT_BITS-1:0]  launchLastCount;
  logic [NUM_CORES-1:0] freeMask;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] finishMask;
  logic [WIDE-1:0]      finishCount;
  logic [WIDE-1:0]      completed_d;
  logic                 canDispatch;
  logic [CNT_BITS-1:0]  nextBlockCount;

  // Block count for a launch. The last block holds whatever remains after the full blocks.
  always_comb begin
    launchBlocks    = (WIDE'(bus.thread_count) + WIDE'(THREADS_PER_BLOCK - 1)) >> LOG_TPB;
    launchLastCount = CNT_BITS'(WIDE'(bus.thread_count) - ((launchBlocks - WIDE'(1)) << LOG_TPB));
  end

  // Free-core grant: the lowest set bit of the free mask. Cores finishing this edge are still busy here.
  always_comb begin
    freeMask       = coreReset_q & ~coreStart_q;
    grant          = freeMask & (~freeMask + NUM_CORES'(1));
    canDispatch    = (dispatched_q < totalBlocks_q) && (|freeMask);
    nextBlockCount = (dispatched_q == totalBlocks_q - WIDE'(1)) ? lastCount_q
                                                                : CNT_BITS'(THREADS_PER_BLOCK);
  end

  // Completions count only on cores that are actually running a block.
  always_comb begin
    finishMask  = bus.core_done & coreStart_q;
    finishCount = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      finishCount = finishCount + WIDE'(finishMask[i]);
    end
    completed_d = completed_q + finishCount;
  end

  // Dispatcher state machine. Every output is a register written here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      coreStart_q       <= '0;
      coreReset_q       <= '1;
      coreBlockId_q     <= '0;
      coreThreadCount_q <= '0;
      totalBlocks_q     <= '0;
      dispatched_q      <= '0;
      completed_q       <= '0;
      lastCount_q       <= '0;
      done_q            <= 1'b0;
      busy_q            <= 1'b0;
      aborted_q         <= 1'b0;
      kernelCycles_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            totalBlocks_q  <= launchBlocks;
            lastCount_q    <= launchLastCount;
            dispatched_q   <= '0;
            completed_q    <= '0;
            kernelCycles_q <= '0;
            aborted_q      <= 1'b0;
            if (bus.thread_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DISPATCH;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          if (!(&kernelCycles_q)) begin
            kernelCycles_q <= kernelCycles_q + CYCLE_COUNT_BITS'(1);
          end
          if (bus.abort) begin
            coreStart_q <= '0;
            coreReset_q <= '1;
            done_q      <= 1'b1;
            aborted_q   <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (finishMask[i]) begin
                coreStart_q[i] <= 1'b0;
                coreReset_q[i] <= 1'b1;
              end else if (canDispatch && grant[i]) begin
                coreStart_q[i]       <= 1'b1;
                coreReset_q[i]       <= 1'b0;
                coreBlockId_q[i]     <= BLOCK_ID_BITS'(dispatched_q);
                coreThreadCount_q[i] <= nextBlockCount;
              end
            end
            if (canDispatch) begin
              dispatched_q <= dispatched_q + WIDE'(1);
            end
            completed_q <= completed_d;
            if (completed_d == totalBlocks_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.core_start        = coreStart_q;
  assign bus.core_reset        = coreReset_q;
  assign bus.core_block_id     = coreBlockId_q;
  assign bus.core_thread_count = coreThreadCount_q;
  assign bus.done              = done_q;
  assign bus.busy              = busy_q;
  assign bus.aborted           = aborted_q;
  assign bus.kernel_cycles     = kernelCycles_q;
endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher.
// The reference model keeps a running flag, block ID and thread count per core, plus kernel-level counters.
module tb_block_dispatcher;
  localparam int NC   = 2;
  localparam int TPB  = 4;
  localparam int TCB  = 8;
  localparam int BIDB = 8;
  localparam int CCB  = 16;
  localparam int CNTB = $clog2(TPB) + 1;
  localparam int M_IDLE = 0, M_DISP = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_dispatcher_if #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .THREAD_COUNT_BITS(TCB),
                        .BLOCK_ID_BITS(BIDB), .CYCLE_COUNT_BITS(CCB)) bus ();

  block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB), .THREAD_COUNT_BITS(TCB),
                     .BLOCK_ID_BITS(BIDB), .CYCLE_COUNT_BITS(CCB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  int mState;
  bit mRun [NC];
  int mId  [NC];
  int mCnt [NC];
  int mTotal, mNext, mCompleted, mThreads, mCycles;
  bit mDone, mAborted;

  // Reference model state after a reset.
  function automatic void modelReset();
    mState = M_IDLE;
    for (int i = 0; i < NC; i++) begin
      mRun[i] = 1'b0; mId[i] = 0; mCnt[i] = 0;
    end
    mTotal = 0; mNext = 0; mCompleted = 0; mThreads = 0; mCycles = 0;
    mDone = 1'b0; mAborted = 1'b0;
  endfunction

  // Reference model: the effect of one clock edge with the given inputs.
  function automatic void modelStep(bit s, bit a, int tc, bit [NC-1:0] cd);
    bit was [NC];
    int pick;
    was = mRun;
    if (mState != M_DISP) begin
      if (s) begin
        mTotal = (tc + TPB - 1) / TPB;
        mThreads = tc; mNext = 0; mCompleted = 0; mCycles = 0; mAborted = 1'b0;
        mDone  = (tc == 0);
        mState = (tc == 0) ? M_DONE : M_DISP;
      end
    end else begin
      mCycles = (mCycles < (1 << CCB) - 1) ? mCycles + 1 : (1 << CCB) - 1;
      if (a) begin
        for (int i = 0; i < NC; i++) mRun[i] = 1'b0;
        mDone = 1'b1; mAborted = 1'b1; mState = M_DONE;
      end else begin
        pick = -1;
        for (int i = NC - 1; i >= 0; i--) if (!was[i]) pick = i;
        if (pick >= 0 && mNext < mTotal) begin
          mRun[pick] = 1'b1;
          mId[pick]  = mNext;
          mCnt[pick] = (mNext == mTotal - 1) ? mThreads - TPB * (mTotal - 1) : TPB;
          mNext++;
        end
        for (int i = 0; i < NC; i++) begin
          if (was[i] && cd[i]) begin
            mRun[i] = 1'b0;
            mCompleted++;
          end
        end
        if (mCompleted == mTotal) begin
          mState = M_DONE; mDone = 1'b1;
        end
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model and the DUT by one edge, and settle past the edge.
  task automatic applyStimulus(input bit s, input bit a, input int tc, input bit [NC-1:0] cd);
    bus.start        = s;
    bus.abort        = a;
    bus.thread_count = TCB'(tc);
    bus.core_done    = cd;
    modelStep(s, a, tc, cd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.thread_count = '0; bus.core_done = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.core_start, bus.core_reset, bus.done, bus.busy, bus.aborted} !== 7'b00_11_000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b expected %b",
               {bus.core_start, bus.core_reset, bus.done, bus.busy, bus.aborted}, 7'b00_11_000);
    end
    checks++;
    if (bus.kernel_cycles !== '0 || bus.core_block_id !== '0 || bus.core_thread_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got cycles=%0d ids=%h cnts=%h expected all 0",
               bus.kernel_cycles, bus.core_block_id, bus.core_thread_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic8();
    applyStimulus(1, 0, 8, 2'b00);
    checks++;
    if ({bus.busy, bus.core_start, bus.done} !== 4'b1_00_0) begin
      errors++; $display("[TB] FAIL basic_launch got %b expected 1000", {bus.busy, bus.core_start, bus.done});
    end
    applyStimulus(0, 0, 8, 2'b00);
    checks++;
    if (bus.core_start !== 2'b01 || bus.core_block_id[0] !== 8'd0 || bus.core_thread_count[0] !== 3'd4) begin
      errors++; $display("[TB] FAIL basic_core0 got start=%b id=%0d cnt=%0d expected 01/0/4",
                         bus.core_start, bus.core_block_id[0], bus.core_thread_count[0]);
    end
    applyStimulus(0, 0, 8, 2'b00);
    checks++;
    if (bus.core_start !== 2'b11 || bus.core_block_id[1] !== 8'd1 || bus.core_thread_count[1] !== 3'd4) begin
      errors++; $display("[TB] FAIL basic_core1 got start=%b id=%0d cnt=%0d expected 11/1/4",
                         bus.core_start, bus.core_block_id[1], bus.core_thread_count[1]);
    end
    applyStimulus(0, 0, 8, 2'b11);
    checks++;
    if ({bus.done, bus.busy, bus.core_start, bus.core_reset} !== 6'b10_00_11 || bus.kernel_cycles !== 16'd3) begin
      errors++; $display("[TB] FAIL basic_done got ctrl=%b cycles=%0d expected 100011/3",
                         {bus.done, bus.busy, bus.core_start, bus.core_reset}, bus.kernel_cycles);
    end
  endtask

  task automatic test_ten();
    applyStimulus(1, 0, 10, 2'b00);
    applyStimulus(0, 0, 10, 2'b00);
    applyStimulus(0, 0, 10, 2'b00);
    applyStimulus(0, 0, 10, 2'b01);
    checks++;
    if (bus.core_start !== 2'b10 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL ten_free0 got start=%b done=%b expected 10/0", bus.core_start, bus.done);
    end
    applyStimulus(0, 0, 10, 2'b00);
    checks++;
    if (bus.core_start !== 2'b11 || bus.core_block_id[0] !== 8'd2 || bus.core_thread_count[0] !== 3'd2) begin
      errors++; $display("[TB] FAIL ten_last got start=%b id=%0d cnt=%0d expected 11/2/2",
                         bus.core_start, bus.core_block_id[0], bus.core_thread_count[0]);
    end
    applyStimulus(0, 0, 10, 2'b10);
    checks++;
    if (bus.done !== 1'b0 || bus.core_start !== 2'b01) begin
      errors++; $display("[TB] FAIL ten_two_done got done=%b start=%b expected 0/01", bus.done, bus.core_start);
    end
    applyStimulus(0, 0, 10, 2'b01);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL ten_done got done=%b busy=%b expected 1/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_zero();
    applyStimulus(1, 0, 0, 2'b00);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.done, bus.busy, bus.core_start} !== 4'b1_0_00) begin
        errors++; $display("[TB] FAIL zero_kernel step %0d got %b expected 1000", k, {bus.done, bus.busy, bus.core_start});
      end
      applyStimulus(0, 0, 0, 2'b11);
    end
  endtask

  task automatic test_ignore_unstarted();
    applyStimulus(1, 0, 4, 2'b00);
    applyStimulus(0, 0, 4, 2'b10);
    applyStimulus(0, 0, 4, 2'b10);
    checks++;
    if (bus.core_start !== 2'b01 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL ignore_unstarted got start=%b done=%b expected 01/0", bus.core_start, bus.done);
    end
    applyStimulus(0, 0, 4, 2'b01);
    checks++;
    if (bus.done !== 1'b1 || bus.core_start !== 2'b00) begin
      errors++; $display("[TB] FAIL ignore_finish got done=%b start=%b expected 1/00", bus.done, bus.core_start);
    end
  endtask

  task automatic test_abort();
    applyStimulus(1, 0, 40, 2'b00);
    applyStimulus(0, 0, 40, 2'b00);
    applyStimulus(0, 0, 40, 2'b00);
    applyStimulus(0, 1, 40, 2'b00);
    checks++;
    if ({bus.core_start, bus.core_reset, bus.done, bus.aborted, bus.busy} !== 7'b00_11_110 || bus.kernel_cycles !== 16'd3) begin
      errors++; $display("[TB] FAIL abort got ctrl=%b cycles=%0d expected 0011110/3",
                         {bus.core_start, bus.core_reset, bus.done, bus.aborted, bus.busy}, bus.kernel_cycles);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 40, 2'b11);
      checks++;
      if (bus.kernel_cycles !== 16'd3 || bus.done !== 1'b1 || bus.aborted !== 1'b1) begin
        errors++; $display("[TB] FAIL abort_hold got cycles=%0d done=%b aborted=%b expected 3/1/1",
                           bus.kernel_cycles, bus.done, bus.aborted);
      end
    end
  endtask

  task automatic test_relaunch255();
    bit seen;
    int budget;
    applyStimulus(1, 0, 255, 2'b00);
    checks++;
    if ({bus.done, bus.aborted, bus.busy} !== 3'b001 || bus.kernel_cycles !== '0) begin
      errors++; $display("[TB] FAIL relaunch got done/aborted/busy=%b cycles=%0d expected 001/0",
                         {bus.done, bus.aborted, bus.busy}, bus.kernel_cycles);
    end
    seen = 1'b0;
    budget = 0;
    while (!bus.done && budget < 1000) begin
      applyStimulus(0, 0, 255, 2'($urandom_range(0, 3)));
      budget++;
      for (int i = 0; i < NC; i++) begin
        if (!seen && bus.core_start[i] && bus.core_block_id[i] == 8'd63) begin
          seen = 1'b1;
          checks++;
          if (bus.core_thread_count[i] !== 3'd3) begin
            errors++; $display("[TB] FAIL last_block_cnt got %0d expected 3", bus.core_thread_count[i]);
          end
        end
      end
    end
    checks++;
    if (!bus.done || !seen) begin
      errors++; $display("[TB] FAIL relaunch_finish got done=%b last_seen=%b expected 1/1", bus.done, seen);
    end
    checks++;
    if (bus.kernel_cycles !== CCB'(mCycles)) begin
      errors++; $display("[TB] FAIL relaunch_cycles got %0d expected %0d", bus.kernel_cycles, mCycles);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1, 0, 40, 2'b00);
    applyStimulus(0, 0, 40, 2'b00);
    applyStimulus(0, 0, 40, 2'b00);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.core_reset, bus.core_start, bus.done, bus.busy} !== 6'b11_00_00) begin
      errors++; $display("[TB] FAIL async_reset got %b expected 110000",
                         {bus.core_reset, bus.core_start, bus.done, bus.busy});
    end
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [NC-1:0]           expS;
    logic [NC-1:0][BIDB-1:0] expId;
    logic [NC-1:0][CNTB-1:0] expC;
    int tc;
    for (int c = 0; c < 3000; c++) begin
      tc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0, tc, 2'($urandom_range(0, 3)));
      for (int i = 0; i < NC; i++) begin
        expS[i]  = mRun[i];
        expId[i] = BIDB'(mId[i]);
        expC[i]  = CNTB'(mCnt[i]);
      end
      checks++;
      if ({bus.core_start, bus.core_reset, bus.done, bus.busy, bus.aborted} !==
          {expS, ~expS, mDone, mState == M_DISP, mAborted}) begin
        errors++; $display("[TB] FAIL random_ctrl cycle %0d got %b expected %b", c,
                           {bus.core_start, bus.core_reset, bus.done, bus.busy, bus.aborted},
                           {expS, ~expS, mDone, mState == M_DISP, mAborted});
      end
      checks++;
      if (bus.core_block_id !== expId || bus.core_thread_count !== expC) begin
        errors++; $display("[TB] FAIL random_blocks cycle %0d got ids=%h cnts=%h expected ids=%h cnts=%h",
                           c, bus.core_block_id, bus.core_thread_count, expId, expC);
      end
      checks++;
      if (bus.kernel_cycles !== CCB'(mCycles)) begin
        errors++; $display("[TB] FAIL random_cycles cycle %0d got %0d expected %0d", c, bus.kernel_cycles, mCycles);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic8();
    test_ten();
    test_zero();
    test_ignore_unstarted();
    test_abort();
    test_relaunch255();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
